// File: rtl/bash_line_buffer.sv
// rtl/bash_line_buffer.sv - keyboard line editor: collects printable keys with backspace,
// then presents the committed line to a byte-at-a-time consumer.
module bash_line_buffer #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  output logic       out_newASCII_ready,
  output logic [5:0] out_lineLen,
  output logic [7:0] lineOut,
  input  logic       lineOut_nextASCII,
  output logic       echo_valid,
  output logic [7:0] echo_ascii,
  output logic       key_dropped
);

  typedef enum logic {EDIT, SEND} state_t;

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] line_len_q, line_len_d;
  logic       ready_q, ready_d;
  logic       echo_valid_q, echo_valid_d;
  logic [7:0] echo_ascii_q, echo_ascii_d;
  logic       key_dropped_q, key_dropped_d;

  logic [7:0] line_mem [32];
  logic       mem_we;
  logic       printable;

  assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    line_len_d    = line_len_q;
    ready_d       = ready_q;
    echo_valid_d  = 1'b0;
    echo_ascii_d  = echo_ascii_q;
    key_dropped_d = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      EDIT: begin
        if (key_valid) begin
          if (printable) begin
            if (len_q < MAX_LEN_C) begin
              mem_we       = 1'b1;
              len_d        = len_q + 6'd1;
              echo_valid_d = 1'b1;
              echo_ascii_d = key_ascii;
            end else begin
              key_dropped_d = 1'b1;
            end
          end else if (key_ascii == 8'h08) begin
            if (len_q != 6'd0) begin
              len_d        = len_q - 6'd1;
              echo_valid_d = 1'b1;
              echo_ascii_d = 8'h08;
            end
          end else if (key_ascii == 8'h0D) begin
            line_len_d = len_q;
            idx_d      = 6'd0;
            state_d    = SEND;
            ready_d    = 1'b1;
          end
        end
      end
      SEND: begin
        key_dropped_d = key_valid;
        // The terminator cycle (idx at length) is shown once, then the line is released.
        if (idx_q >= line_len_q) begin
          state_d = EDIT;
          len_d   = 6'd0;
          idx_d   = 6'd0;
          ready_d = 1'b0;
        end else if (lineOut_nextASCII) begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EDIT;
      len_q         <= 6'd0;
      idx_q         <= 6'd0;
      line_len_q    <= 6'd0;
      ready_q       <= 1'b0;
      echo_valid_q  <= 1'b0;
      echo_ascii_q  <= 8'h00;
      key_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      line_len_q    <= line_len_d;
      ready_q       <= ready_d;
      echo_valid_q  <= echo_valid_d;
      echo_ascii_q  <= echo_ascii_d;
      key_dropped_q <= key_dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) line_mem[len_q[4:0]] <= key_ascii;
  end

  assign lineOut = (state_q == SEND && idx_q < line_len_q) ? line_mem[idx_q[4:0]] : 8'h00;

  assign out_newASCII_ready = ready_q;
  assign out_lineLen        = line_len_q;
  assign echo_valid         = echo_valid_q;
  assign echo_ascii         = echo_ascii_q;
  assign key_dropped        = key_dropped_q;

endmodule
